// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_id_stage
// Description : IF/ID pipeline register for the 16-bit five-stage CPU.
//               Holds the fetched PC+2 and instruction. Detects load-use
//               hazards against EX and handles taken-branch flushes. Drives
//               the PC write enable and the ID/EX bubble request. Runs the
//               RUN/HALT machine for HLT and keeps saturating stall and
//               flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  OPC_LW    = 4'h8,
  parameter logic [3:0]  OPC_SW    = 4'h9,
  parameter logic [3:0]  OPC_HLT   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,            // asynchronous, active-low
  input  logic [15:0] pc_new,
  input  logic [15:0] instr_new,
  input  logic        idex_memtoreg,
  input  logic [3:0]  idex_rd,
  input  logic        branch_taken,
  output logic [15:0] pc_current,
  output logic [15:0] instr_current,
  output logic        valid_current,
  output logic        pc_wen,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [15:0] flush_count
);

  // Opcodes that change which instruction fields are register sources
  localparam logic [3:0]  c_opc_llb = 4'hA;
  localparam logic [3:0]  c_opc_lhb = 4'hB;
  localparam logic [3:0]  c_opc_b   = 4'hC;
  localparam logic [15:0] c_cnt_max = 16'hFFFF;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic        r_valid;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic [15:0] w_pc_next;
  logic [15:0] w_instr_next;
  logic        w_valid_next;
  logic        w_pc_wen;
  logic        w_idex_bubble;
  logic        w_stall_inc;
  logic        w_flush_inc;

  logic [3:0]  w_op;
  logic [3:0]  w_src_hi;
  logic [3:0]  w_src_rs;
  logic [3:0]  w_src_rt;
  logic        w_use_hi;
  logic        w_use_rs;
  logic        w_use_rt;
  logic        w_hazard;

  // Source-register decode of the instruction currently held in IF/ID
  always_comb begin
    w_op     = r_instr[15:12];
    w_src_hi = r_instr[11:8];
    w_src_rs = r_instr[7:4];
    w_src_rt = r_instr[3:0];
    // LLB/LHB carry an immediate in [7:0]; B carries condition/offset there
    w_use_rs = (w_op != c_opc_llb) && (w_op != c_opc_lhb) && (w_op != c_opc_b);
    // Register-register ALU ops read the second operand from [3:0]
    w_use_rt = (w_op[3] == 1'b0);
    // SW reads its data register from [11:8]; LLB/LHB read-modify-write it.
    // LW names its destination there, so it must never count as a source.
    w_use_hi = ((w_op == OPC_SW) || (w_op == c_opc_llb) || (w_op == c_opc_lhb))
               && (w_op != OPC_LW);
    w_hazard = r_valid && idex_memtoreg && (idex_rd != 4'd0) &&
               ((w_use_rs && (w_src_rs == idex_rd)) ||
                (w_use_rt && (w_src_rt == idex_rd)) ||
                (w_use_hi && (w_src_hi == idex_rd)));
  end

  // Next-state and pipeline control: HALT > hazard > HLT entry > flush > normal
  always_comb begin
    w_state_next  = r_state;
    w_pc_wen      = 1'b1;
    w_idex_bubble = 1'b0;
    w_pc_next     = r_pc;
    w_instr_next  = r_instr;
    w_valid_next  = r_valid;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      ST_HALT: begin
        // Frozen: IF/ID already holds the bubble, only reset leaves here
        w_pc_wen      = 1'b0;
        w_idex_bubble = 1'b1;
      end
      ST_RUN: begin
        if (w_hazard) begin
          // Hold fetch and IF/ID; the load moves to MEM and clears this
          w_pc_wen      = 1'b0;
          w_idex_bubble = 1'b1;
          w_stall_inc   = 1'b1;
        end else if (r_valid && (w_op == OPC_HLT)) begin
          // HLT itself flows into ID/EX; nothing fetched behind it survives
          w_pc_wen     = 1'b0;
          w_instr_next = NOP_INSTR;
          w_valid_next = 1'b0;
          w_state_next = ST_HALT;
        end else if (r_valid && branch_taken) begin
          // Squash the wrong-path instruction fetched behind the branch
          w_pc_next    = pc_new;
          w_instr_next = NOP_INSTR;
          w_valid_next = 1'b0;
          w_flush_inc  = 1'b1;
        end else begin
          w_pc_next    = pc_new;
          w_instr_next = instr_new;
          w_valid_next = 1'b1;
        end
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= 16'd0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_valid <= w_valid_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != c_cnt_max)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_flush_inc && (r_flush_cnt != c_cnt_max)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign pc_current    = r_pc;
  assign instr_current = r_instr;
  assign valid_current = r_valid;
  assign pc_wen        = w_pc_wen;
  assign idex_bubble   = w_idex_bubble;
  assign halted        = (r_state == ST_HALT);
  assign stall_count   = r_stall_cnt;
  assign flush_count   = r_flush_cnt;

endmodule
`default_nettype wire
